div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter_if.sv | 25 ++
 rtl/div_arbiter.sv | 172 +++++++++++++++++
 tb/tb_div_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// Requester-side bundle of the divider arbiter: request handshake, operand
// buses and the shared response bus. The arbiter takes the slave side.
interface div_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ-1:0]    resp_ready;
  logic [31:0]         resp_q;
  logic [31:0]         resp_r;
  logic                resp_dz;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_q, resp_r, resp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_q, resp_r, resp_dz
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one serial divider between N_REQ requesters.
// One operation is in flight at a time; divide-by-zero is answered locally
// without starting the divider. After reset the block waits out a full
// divider latency so an operation aborted by reset cannot corrupt the next.
module div_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clock,
  input  logic        reset,
  div_arbiter_if.slave bus,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SLOT_W = IDX_W + 1;
  localparam int CNT_W  = $clog2(DIV_CYCLES + 1);

  localparam logic [2:0] S_DRAIN  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_WAIT = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_N   = SLOT_W'(N_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [SLOT_W-1:0] slot;
  logic [31:0]      sel_a, sel_b;

  // Find the first valid requester at or after rr_q (wrapping) and pick its operands.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    slot      = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot = {1'b0, rr_q} + SLOT_W'(i);
      if (slot >= SLOT_N) slot = slot - SLOT_N;
      if (!gnt_found && bus.req_valid[slot[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = slot[IDX_W-1:0];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        sel_a = bus.req_a[32*k +: 32];
        sel_b = bus.req_b[32*k +: 32];
      end
    end
  end

  // Next-state logic: drain, arbitrate, launch, wait out the divider, hold the response.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_IDLE: begin
        if (gnt_found) begin
          owner_d = gnt_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          if (sel_b == '0) begin
            quo_d   = '1;
            rem_d   = sel_a;
            dz_d    = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = CNT_WAIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          quo_d   = div_q;
          rem_d   = div_r;
          dz_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RESP: begin
        if (bus.resp_ready[owner_q]) begin
          rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_ONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_DRAIN;
    endcase
  end

  // State registers; reset abandons any operation and restarts the drain period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_DRAIN;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= CNT_INIT;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Strobes are masked by reset so nothing is granted or delivered while it is held.
  assign bus.req_ready  = (!reset && state_q == S_IDLE && gnt_found) ?
                          (N_REQ'(1) << gnt_idx) : '0;
  assign bus.resp_valid = (!reset && state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign bus.resp_q     = quo_q;
  assign bus.resp_r     = rem_q;
  assign bus.resp_dz    = dz_q;

  assign busy      = reset || (state_q != S_IDLE);
  assign div_start = !reset && (state_q == S_LAUNCH);
  assign div_a     = a_q;
  assign div_b     = b_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a behavioural serial-divider model plus a
// round-robin reference that predicts owner, latency and result per request.
module tb_div_arbiter;

  localparam int NR = 4;
  localparam int DIV_CYCLES = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy, div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_q = 32'h0;
  logic [31:0] div_r = 32'h0;

  div_arbiter_if #(.N_REQ(NR)) bus ();

  div_arbiter #(.N_REQ(NR), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r)
  );

  int          cyc = 0;
  int          startCyc = -1000000;
  int          checks = 0;
  int          errors = 0;
  int          rrExp = 0;
  logic [3:0]  vld = 4'b0;
  logic [31:0] opA [NR];
  logic [31:0] opB [NR];

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle index, stable across each clock period.
  always @(posedge clock) cyc <= cyc + 1;

  // Serial divider: results become valid DIV_CYCLES cycles after the start cycle, garbage before.
  always @(negedge clock) begin
    if (div_start) startCyc <= cyc;
    if ((cyc - (div_start ? cyc : startCyc)) >= DIV_CYCLES && div_b != 32'h0) begin
      div_q <= div_a / div_b;
      div_r <= div_a % div_b;
    end else begin
      div_q <= 32'hDEAD_BEEF;
      div_r <= 32'hBAAD_F00D;
    end
  end

  // Run-time limit.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int pickGrant();
    for (int i = 0; i < NR; i++) begin
      if (vld[(rrExp + i) % NR]) return (rrExp + i) % NR;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    bus.req_valid = vld;
    for (int k = 0; k < NR; k++) begin
      bus.req_a[32*k +: 32] = opA[k];
      bus.req_b[32*k +: 32] = opB[k];
    end
  endtask

  task automatic newOps(input int k);
    opA[k] = $urandom;
    case ($urandom_range(0, 5))
      0:       opB[k] = 32'h0;
      1:       opB[k] = $urandom_range(1, 15);
      default: opB[k] = $urandom;
    endcase
  endtask

  task automatic doReset();
    int n;
    int g;
    logic bad;
    @(posedge clock); #1;
    reset = 1'b1;
    bus.resp_ready = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 1", busy); end
    checks++;
    if (bus.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    checks++;
    if (bus.resp_valid !== 4'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b expected 0000", bus.resp_valid); end
    checks++;
    if (div_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_div_start: got %b expected 0", div_start); end
    checks++;
    if ({bus.resp_q, bus.resp_r, bus.resp_dz} !== 65'h0) begin
      errors++;
      $display("[TB] FAIL rst_resp: got q=%h r=%h dz=%b expected all zero", bus.resp_q, bus.resp_r, bus.resp_dz);
    end
    checks++;
    if ({div_a, div_b} !== 64'h0) begin errors++; $display("[TB] FAIL rst_div_ops: got a=%h b=%h expected 0", div_a, div_b); end
    @(posedge clock); #1;
    reset = 1'b0;
    rrExp = 0;
    n = 0;
    bad = 1'b0;
    @(negedge clock);
    while (busy === 1'b1 && n < 200) begin
      if (bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0 || div_start !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clock);
    end
    checks++;
    if (n != DIV_CYCLES) begin errors++; $display("[TB] FAIL drain_len: got %0d expected %0d", n, DIV_CYCLES); end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL drain_quiet: got activity expected none"); end
    g = pickGrant();
    checks++;
    if (bus.req_ready !== ((g < 0) ? 4'b0 : (4'b0001 << g))) begin
      errors++;
      $display("[TB] FAIL idle_grant: got %b expected grant %0d", bus.req_ready, g);
    end
  endtask

  // Serve the next request predicted by the model; must be called at a negedge.
  task automatic serveNext(input int stall, input bit refill, input logic [3:0] ghost, output int owner);
    int g, n, t0, lat, expLat;
    logic [31:0] a, b, eq, er, hq, hr;
    logic edz, hdz, bad;
    logic [3:0] hv;
    owner = -1;
    g = pickGrant();
    checks++;
    if (g < 0) begin errors++; $display("[TB] FAIL pick: got none expected a valid requester"); return; end
    n = 0;
    while (bus.req_ready === 4'b0 && n < 50) begin @(negedge clock); n++; end
    if (bus.req_ready !== (4'b0001 << g)) begin
      errors++;
      $display("[TB] FAIL grant: got %b expected %b", bus.req_ready, 4'b0001 << g);
      return;
    end
    t0 = cyc;
    a = opA[g];
    b = opB[g];
    if (b == 32'h0) begin eq = 32'hFFFF_FFFF; er = a; edz = 1'b1; expLat = 1; end
    else begin eq = a / b; er = a % b; edz = 1'b0; expLat = DIV_CYCLES + 2; end
    @(posedge clock); #1;
    if (refill) newOps(g);
    else vld[g] = 1'b0;
    applyStimulus();
    bad = 1'b0;
    n = 0;
    @(negedge clock);
    while (bus.resp_valid === 4'b0 && n < 100) begin
      if (bus.req_ready !== 4'b0) bad = 1'b1;
      if (div_start !== (b != 32'h0 && cyc == t0 + 1)) bad = 1'b1;
      if (div_a !== a || div_b !== b) bad = 1'b1;
      if (cyc == t0 + 5) bus.req_valid = vld | ghost;
      if (cyc == t0 + 10) bus.req_valid = vld;
      @(negedge clock);
      n++;
    end
    if (div_start !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL wait_phase owner %0d: got protocol error expected clean launch/wait", g); end
    lat = cyc - t0;
    checks++;
    if (lat != expLat) begin errors++; $display("[TB] FAIL latency owner %0d: got %0d expected %0d", g, lat, expLat); end
    checks++;
    if (bus.resp_valid !== (4'b0001 << g)) begin
      errors++;
      $display("[TB] FAIL resp_valid: got %b expected %b", bus.resp_valid, 4'b0001 << g);
    end
    checks++;
    if (bus.resp_q !== eq) begin errors++; $display("[TB] FAIL resp_q a=%h b=%h: got %h expected %h", a, b, bus.resp_q, eq); end
    checks++;
    if (bus.resp_r !== er) begin errors++; $display("[TB] FAIL resp_r a=%h b=%h: got %h expected %h", a, b, bus.resp_r, er); end
    checks++;
    if (bus.resp_dz !== edz) begin errors++; $display("[TB] FAIL resp_dz: got %b expected %b", bus.resp_dz, edz); end
    hv = bus.resp_valid;
    hq = bus.resp_q;
    hr = bus.resp_r;
    hdz = bus.resp_dz;
    bad = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      bus.resp_ready = 4'($urandom) & ~(4'b0001 << g);
      @(negedge clock);
      if (bus.resp_valid !== hv || bus.resp_q !== hq || bus.resp_r !== hr || bus.resp_dz !== hdz ||
          bus.req_ready !== 4'b0 || busy !== 1'b1) bad = 1'b1;
    end
    if (stall > 0) begin
      checks++;
      if (bad) begin errors++; $display("[TB] FAIL resp_hold owner %0d: got change during stall expected stable", g); end
    end
    @(posedge clock); #1;
    bus.resp_ready = (4'b0001 << g) | 4'($urandom);
    @(negedge clock);
    @(posedge clock); #1;
    bus.resp_ready = 4'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL consume: got busy=%b resp_valid=%b expected 0/0000", busy, bus.resp_valid);
    end
    rrExp = (g + 1) % NR;
    owner = g;
  endtask

  task automatic test_reset();
    logic bad;
    doReset();
    bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (busy !== 1'b0 || bus.req_ready !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL idle_after_reset: got busy/grant expected quiet idle"); end
  endtask

  task automatic test_basic();
    int o;
    @(posedge clock); #1;
    opA[0] = 32'd100;
    opB[0] = 32'd7;
    vld = 4'b0001;
    applyStimulus();
    @(negedge clock);
    serveNext(0, 1'b0, 4'b0, o);
    checks++;
    if (o != 0) begin errors++; $display("[TB] FAIL basic_owner: got %0d expected 0", o); end
  endtask

  task automatic test_div_zero();
    int o;
    @(posedge clock); #1;
    opA[2] = 32'd55;
    opB[2] = 32'd0;
    vld = 4'b0100;
    applyStimulus();
    @(negedge clock);
    serveNext(0, 1'b0, 4'b0, o);
    checks++;
    if (o != 2) begin errors++; $display("[TB] FAIL dz_owner: got %0d expected 2", o); end
  endtask

  task automatic test_stall();
    int o;
    @(posedge clock); #1;
    opA[1] = 32'd9999;
    opB[1] = 32'd13;
    opA[2] = 32'd4242;
    opB[2] = 32'd0;
    vld = 4'b0110;
    applyStimulus();
    @(negedge clock);
    serveNext(10, 1'b0, 4'b0, o);
    checks++;
    if (o != 1) begin errors++; $display("[TB] FAIL stall_owner: got %0d expected 1", o); end
    serveNext(0, 1'b0, 4'b0, o);
  endtask

  task automatic test_fairness();
    int o;
    int guard;
    doReset();
    @(posedge clock); #1;
    for (int k = 0; k < NR; k++) begin
      opA[k] = 32'd1000 + 32'(k * 377);
      opB[k] = 32'(k + 3);
    end
    vld = 4'b1111;
    applyStimulus();
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      serveNext(0, 1'b1, 4'b0, o);
      checks++;
      if (o != i % NR) begin errors++; $display("[TB] FAIL rr_order step %0d: got %0d expected %0d", i, o, i % NR); end
    end
    guard = 0;
    while (vld != 4'b0 && guard < 8) begin serveNext(0, 1'b0, 4'b0, o); guard++; end
  endtask

  task automatic test_withdraw();
    int o;
    logic bad;
    @(posedge clock); #1;
    opA[0] = 32'd5000;
    opB[0] = 32'd3;
    vld = 4'b0001;
    applyStimulus();
    @(negedge clock);
    serveNext(0, 1'b0, 4'b1100, o);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (busy !== 1'b0 || bus.req_ready !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL withdraw: got remembered grant expected none"); end
  endtask

  task automatic test_reset_mid_wait();
    int o, n, t0;
    logic bad;
    @(posedge clock); #1;
    opA[1] = 32'd12345;
    opB[1] = 32'd99;
    vld = 4'b0010;
    applyStimulus();
    @(negedge clock);
    n = 0;
    while (bus.req_ready === 4'b0 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL midwait_grant: got %b expected 0010", bus.req_ready); end
    t0 = cyc;
    @(posedge clock); #1;
    opA[3] = 32'd777;
    opB[3] = 32'd5;
    vld = 4'b1000;
    applyStimulus();
    bad = 1'b0;
    @(negedge clock);
    while (cyc < t0 + 23) begin
      if (bus.resp_valid !== 4'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL midwait_pre: got early response expected waiting"); end
    doReset();
    serveNext(2, 1'b0, 4'b0, o);
    checks++;
    if (o != 3) begin errors++; $display("[TB] FAIL midwait_next_owner: got %0d expected 3", o); end
  endtask

  task automatic test_random();
    int o;
    int guard;
    logic [3:0] m;
    for (int it = 0; it < 16; it++) begin
      if (vld == 4'b0) begin
        @(posedge clock); #1;
        m = 4'($urandom_range(1, 15));
        for (int k = 0; k < NR; k++) if (m[k]) newOps(k);
        vld = m;
        applyStimulus();
        @(negedge clock);
      end
      serveNext($urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'b0, o);
    end
    guard = 0;
    while (vld != 4'b0 && guard < 8) begin serveNext(0, 1'b0, 4'b0, o); guard++; end
  endtask

  // Test sequence.
  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    for (int k = 0; k < NR; k++) begin opA[k] = 32'h0; opB[k] = 32'h0; end
    $display("[TB] div_arbiter bench start");
    test_reset();
    test_basic();
    test_div_zero();
    test_stall();
    test_fairness();
    test_withdraw();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
